// File: rtl/exist_return_unit.sv
// -----------------------------------------------------------------------------
// exist_return_unit
//
// Return-path stage of the existential-quantification engine. A completed
// recursion frame (top variable, cube flag, low/high cofactor results, tag)
// is reduced to its final BDD index. Trivial frames resolve locally. Others
// send a make-node request to the unique table or an OR request to the apply
// unit, wait for the acknowledge, then return that index. One frame in flight.
//
// Optional feature macro: EXIST_OR_SHORTCUT_EN
//   defined   -> in-cube frames with a terminal or duplicated operand resolve
//                locally
//   undefined -> every in-cube frame issues an OR request
//
// Ports
//   clk, reset                      clock, synchronous active-high reset
//   frame_valid/frame_ready         frame input handshake
//   frame_var/_in_cube/_low/_high   frame contents
//   frame_tag                       opaque frame identifier
//   result_valid/result_ready       result output handshake
//   result, result_tag              final index and originating tag
//   mk_valid/mk_ready               make-node request handshake
//   mk_var/mk_low/mk_high           make-node fields
//   mk_ack_valid/mk_ack_index       unique-table answer
//   or_valid/or_ready               OR request handshake
//   or_a/or_b                       OR operands
//   or_ack_valid/or_ack_index       apply-unit answer
// -----------------------------------------------------------------------------
`ifndef VAR_DEF
`define VAR_DEF [7:0]
`endif
`ifndef INDEX_DEF
`define INDEX_DEF [15:0]
`endif
`ifndef BDD_ZERO
`define BDD_ZERO 16'd0
`endif
`ifndef BDD_ONE
`define BDD_ONE 16'd1
`endif

module exist_return_unit #(
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 frame_valid,
    output logic                 frame_ready,
    input  logic `VAR_DEF        frame_var,
    input  logic                 frame_in_cube,
    input  logic `INDEX_DEF      frame_low,
    input  logic `INDEX_DEF      frame_high,
    input  logic [TAG_WIDTH-1:0] frame_tag,
    output logic                 result_valid,
    input  logic                 result_ready,
    output logic `INDEX_DEF      result,
    output logic [TAG_WIDTH-1:0] result_tag,
    output logic                 mk_valid,
    input  logic                 mk_ready,
    output logic `VAR_DEF        mk_var,
    output logic `INDEX_DEF      mk_low,
    output logic `INDEX_DEF      mk_high,
    input  logic                 mk_ack_valid,
    input  logic `INDEX_DEF      mk_ack_index,
    output logic                 or_valid,
    input  logic                 or_ready,
    output logic `INDEX_DEF      or_a,
    output logic `INDEX_DEF      or_b,
    input  logic                 or_ack_valid,
    input  logic `INDEX_DEF      or_ack_index
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EVAL    = 3'd1,
        MK_REQ  = 3'd2,
        MK_WAIT = 3'd3,
        OR_REQ  = 3'd4,
        OR_WAIT = 3'd5,
        OUT     = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    logic `VAR_DEF          var_q;
    logic                   in_cube_q;
    logic `INDEX_DEF        low_q, high_q;
    logic [TAG_WIDTH-1:0]   tag_q;
    logic `INDEX_DEF        result_q, result_d;
    logic [TAG_WIDTH-1:0]   result_tag_q, result_tag_d;

    logic                   accept;
    logic                   eval_local;
    logic `INDEX_DEF        eval_result;

    assign accept = (state_q == IDLE) && frame_valid && !reset;

    // Local resolution of the registered frame, evaluated while in EVAL.
    always_comb begin
        eval_local  = 1'b0;
        eval_result = low_q;
        if (!in_cube_q) begin
            if (low_q == high_q) begin
                eval_local  = 1'b1;
                eval_result = low_q;
            end
        end else begin
`ifdef EXIST_OR_SHORTCUT_EN
            // Priority matters: a ONE operand dominates before ZERO elision.
            if (low_q == `BDD_ONE || high_q == `BDD_ONE) begin
                eval_local  = 1'b1;
                eval_result = `BDD_ONE;
            end else if (low_q == `BDD_ZERO) begin
                eval_local  = 1'b1;
                eval_result = high_q;
            end else if (high_q == `BDD_ZERO) begin
                eval_local  = 1'b1;
                eval_result = low_q;
            end else if (low_q == high_q) begin
                eval_local  = 1'b1;
                eval_result = low_q;
            end
`endif
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = EVAL;
            EVAL: begin
                if (eval_local)     state_d = OUT;
                else if (in_cube_q) state_d = OR_REQ;
                else                state_d = MK_REQ;
            end
            MK_REQ:  if (mk_ready)     state_d = MK_WAIT;
            MK_WAIT: if (mk_ack_valid) state_d = OUT;
            OR_REQ:  if (or_ready)     state_d = OR_WAIT;
            OR_WAIT: if (or_ack_valid) state_d = OUT;
            OUT:     if (result_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Result capture: acks only count in their own WAIT state.
    always_comb begin
        result_d     = result_q;
        result_tag_d = result_tag_q;
        if (state_q == EVAL && eval_local) begin
            result_d     = eval_result;
            result_tag_d = tag_q;
        end else if (state_q == MK_WAIT && mk_ack_valid) begin
            result_d     = mk_ack_index;
            result_tag_d = tag_q;
        end else if (state_q == OR_WAIT && or_ack_valid) begin
            result_d     = or_ack_index;
            result_tag_d = tag_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            var_q        <= '0;
            in_cube_q    <= 1'b0;
            low_q        <= '0;
            high_q       <= '0;
            tag_q        <= '0;
            result_q     <= '0;
            result_tag_q <= '0;
        end else begin
            if (accept) begin
                var_q     <= frame_var;
                in_cube_q <= frame_in_cube;
                low_q     <= frame_low;
                high_q    <= frame_high;
                tag_q     <= frame_tag;
            end
            result_q     <= result_d;
            result_tag_q <= result_tag_d;
        end
    end

    // Output logic: request data comes straight from the frame registers,
    // which cannot change until the frame returns to IDLE.
    always_comb begin
        frame_ready  = (state_q == IDLE) && !reset;
        result_valid = (state_q == OUT);
        result       = result_q;
        result_tag   = result_tag_q;
        mk_valid     = (state_q == MK_REQ);
        mk_var       = var_q;
        mk_low       = low_q;
        mk_high      = high_q;
        or_valid     = (state_q == OR_REQ);
        or_a         = low_q;
        or_b         = high_q;
    end

endmodule

// File: tb/tb_exist_return_unit.sv
`ifndef VAR_DEF
`define VAR_DEF [7:0]
`endif
`ifndef INDEX_DEF
`define INDEX_DEF [15:0]
`endif
`ifndef BDD_ZERO
`define BDD_ZERO 16'd0
`endif
`ifndef BDD_ONE
`define BDD_ONE 16'd1
`endif

module tb_exist_return_unit;

    logic            clk = 1'b0;
    logic            reset;
    logic            frame_valid, frame_ready, frame_in_cube;
    logic `VAR_DEF   frame_var;
    logic `INDEX_DEF frame_low, frame_high;
    logic [3:0]      frame_tag;
    logic            result_valid, result_ready;
    logic `INDEX_DEF result;
    logic [3:0]      result_tag;
    logic            mk_valid, mk_ready, mk_ack_valid;
    logic `VAR_DEF   mk_var;
    logic `INDEX_DEF mk_low, mk_high, mk_ack_index;
    logic            or_valid, or_ready, or_ack_valid;
    logic `INDEX_DEF or_a, or_b, or_ack_index;

    exist_return_unit #(.TAG_WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .frame_valid(frame_valid), .frame_ready(frame_ready),
        .frame_var(frame_var), .frame_in_cube(frame_in_cube),
        .frame_low(frame_low), .frame_high(frame_high), .frame_tag(frame_tag),
        .result_valid(result_valid), .result_ready(result_ready),
        .result(result), .result_tag(result_tag),
        .mk_valid(mk_valid), .mk_ready(mk_ready),
        .mk_var(mk_var), .mk_low(mk_low), .mk_high(mk_high),
        .mk_ack_valid(mk_ack_valid), .mk_ack_index(mk_ack_index),
        .or_valid(or_valid), .or_ready(or_ready),
        .or_a(or_a), .or_b(or_b),
        .or_ack_valid(or_ack_valid), .or_ack_index(or_ack_index)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]      tag;
        logic `INDEX_DEF idx;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every accepted result is compared against the scoreboard head.
    always @(negedge clk) begin
        if (!reset && result_valid && result_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got idx %0h tag %0h expected none", result, result_tag);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("result_idx", {16'd0, result}, {16'd0, e.idx});
                chk("result_tag", {28'd0, result_tag}, {28'd0, e.tag});
                $display("result idx=%0h tag=%0h (expected idx=%0h tag=%0h)", result, result_tag, e.idx, e.tag);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_result(input logic `INDEX_DEF idx, input logic [3:0] tag);
        exp_t e;
        e.idx = idx;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    // Presents a frame and returns #1 after the accepting edge (state EVAL).
    task automatic send_frame(input logic `VAR_DEF v, input logic c,
                              input logic `INDEX_DEF lo, input logic `INDEX_DEF hi,
                              input logic [3:0] tag);
        int n;
        frame_var     = v;
        frame_in_cube = c;
        frame_low     = lo;
        frame_high    = hi;
        frame_tag     = tag;
        frame_valid   = 1'b1;
        n = 0;
        while (!frame_ready && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) begin
            checks++;
            errors++;
            $display("FAIL frame_accept_timeout: got frame_ready 0 expected 1");
        end
        tick();
        frame_valid = 1'b0;
        $display("frame var=%0h cube=%0b low=%0h high=%0h tag=%0h", v, c, lo, hi, tag);
    endtask

    initial begin
        reset = 1'b1;
        frame_valid = 0; frame_in_cube = 0; frame_var = 0;
        frame_low = 0; frame_high = 0; frame_tag = 0;
        result_ready = 1'b1;
        mk_ready = 0; mk_ack_valid = 0; mk_ack_index = 0;
        or_ready = 0; or_ack_valid = 0; or_ack_index = 0;
        repeat (3) tick();
        chk("rst_result_valid", {31'd0, result_valid}, 32'd0);
        chk("rst_mk_valid", {31'd0, mk_valid}, 32'd0);
        chk("rst_or_valid", {31'd0, or_valid}, 32'd0);
        chk("rst_frame_ready", {31'd0, frame_ready}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        chk("rst_mk_data", {mk_var, mk_low, mk_high[7:0]}, 32'd0);
        chk("rst_or_data", {or_a, or_b}, 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_frame_ready", {31'd0, frame_ready}, 32'd1);

        // 1: local, not in cube, low == high
        expect_result(16'd5, 4'd3);
        send_frame(8'd1, 1'b0, 16'd5, 16'd5, 4'd3);
        chk("t1_cycle1_valid", {31'd0, result_valid}, 32'd0);
        tick();
        chk("t1_cycle2_valid", {31'd0, result_valid}, 32'd1);
        chk("t1_no_mk", {31'd0, mk_valid}, 32'd0);
        tick();

        // 2: make-node with back-pressure, ack 9
        expect_result(16'd9, 4'd4);
        send_frame(8'd2, 1'b0, 16'd5, 16'd7, 4'd4);
        chk("t2_cycle1_mk", {31'd0, mk_valid}, 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t2_mk_valid_held", {31'd0, mk_valid}, 32'd1);
            chk("t2_mk_data", {mk_var, mk_low[7:0], mk_high}, {8'd2, 8'd5, 16'd7});
            tick();
        end
        chk("t2_mk_valid_still", {31'd0, mk_valid}, 32'd1);
        mk_ready = 1'b1;
        tick();
        mk_ready = 1'b0;
        chk("t2_mk_dropped", {31'd0, mk_valid}, 32'd0);
        mk_ack_valid = 1'b1;
        mk_ack_index = 16'd9;
        chk("t2_no_early_result", {31'd0, result_valid}, 32'd0);
        tick();
        mk_ack_valid = 1'b0;
        chk("t2_result_after_ack", {31'd0, result_valid}, 32'd1);
        tick();

        // 3: in cube, low = ZERO, high = 7
        expect_result(16'd7, 4'd5);
        send_frame(8'd3, 1'b1, `BDD_ZERO, 16'd7, 4'd5);
`ifdef EXIST_OR_SHORTCUT_EN
        tick();
        chk("t3_shortcut_valid", {31'd0, result_valid}, 32'd1);
        chk("t3_no_or", {31'd0, or_valid}, 32'd0);
        tick();
`else
        tick();
        chk("t3_or_valid", {31'd0, or_valid}, 32'd1);
        chk("t3_or_data", {or_a, or_b}, {`BDD_ZERO, 16'd7});
        or_ready = 1'b1;
        tick();
        or_ready = 1'b0;
        or_ack_valid = 1'b1;
        or_ack_index = 16'd7;
        tick();
        or_ack_valid = 1'b0;
        chk("t3_result_valid", {31'd0, result_valid}, 32'd1);
        tick();
`endif

        // 4: stray acks in IDLE are ignored
        mk_ack_valid = 1'b1; mk_ack_index = 16'hAA;
        or_ack_valid = 1'b1; or_ack_index = 16'hBB;
        tick();
        mk_ack_valid = 1'b0; or_ack_valid = 1'b0;
        chk("t4_idle_ack_ignored", {31'd0, result_valid}, 32'd0);
        chk("t4_idle_ready", {31'd0, frame_ready}, 32'd1);

        // 4: in cube, low=4 high=6, OR ack 11
        or_ready = 1'b1;
        expect_result(16'd11, 4'd6);
        send_frame(8'd4, 1'b1, 16'd4, 16'd6, 4'd6);
        tick();
        chk("t4_or_valid", {31'd0, or_valid}, 32'd1);
        chk("t4_or_data", {or_a, or_b}, {16'd4, 16'd6});
        tick();
        or_ready = 1'b0;
        chk("t4_or_dropped", {31'd0, or_valid}, 32'd0);
        tick();
        or_ack_valid = 1'b1;
        or_ack_index = 16'd11;
        tick();
        or_ack_valid = 1'b0;
        chk("t4_result_valid", {31'd0, result_valid}, 32'd1);
        tick();

        // 5: reset in MK_WAIT, then a stale ack
        mk_ready = 1'b1;
        send_frame(8'd9, 1'b0, 16'd1, 16'd2, 4'd7);
        tick();
        chk("t5_mk_valid", {31'd0, mk_valid}, 32'd1);
        tick();
        mk_ready = 1'b0;
        reset = 1'b1;
        tick();
        chk("t5_rst_frame_ready", {31'd0, frame_ready}, 32'd0);
        chk("t5_rst_outputs", {29'd0, result_valid, mk_valid, or_valid}, 32'd0);
        chk("t5_rst_mk_data", {mk_var, mk_low[7:0], mk_high}, 32'd0);
        chk("t5_rst_result", {12'd0, result_tag, result}, 32'd0);
        reset = 1'b0;
        mk_ack_valid = 1'b1;
        mk_ack_index = 16'h55;
        tick();
        mk_ack_valid = 1'b0;
        chk("t5_ready_after_rst", {31'd0, frame_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("t5_no_result", {31'd0, result_valid}, 32'd0);
            tick();
        end

        // 6: result back-pressure in OUT
        result_ready = 1'b0;
        expect_result(16'd8, 4'd6);
        send_frame(8'd5, 1'b0, 16'd8, 16'd8, 4'd6);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("t6_valid_held", {31'd0, result_valid}, 32'd1);
            chk("t6_result_stable", {12'd0, result_tag, result}, {12'd0, 4'd6, 16'd8});
            chk("t6_frame_ready_low", {31'd0, frame_ready}, 32'd0);
            tick();
        end
        result_ready = 1'b1;
        tick();
        chk("t6_ready_after_out", {31'd0, frame_ready}, 32'd1);

`ifdef EXIST_OR_SHORTCUT_EN
        // ONE dominates, and a duplicated operand resolves locally
        expect_result(`BDD_ONE, 4'd1);
        send_frame(8'd6, 1'b1, 16'd3, `BDD_ONE, 4'd1);
        tick();
        chk("t7_one_local", {31'd0, result_valid}, 32'd1);
        tick();
        expect_result(16'd12, 4'd2);
        send_frame(8'd6, 1'b1, 16'd12, 16'd12, 4'd2);
        tick();
        chk("t7_dup_local", {31'd0, result_valid}, 32'd1);
        tick();
`endif

        repeat (3) tick();
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
